// File: rtl/parameterized_uart_rx_pkg.sv
// Shared UART definitions: state encoding, bit-timing helpers and parity-type constants.
// The transmitter reuses the subset of states it needs.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/parameterized_uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin.
// RESET_VAL lets idle-high lines (rx, cts) come out of reset in their idle state.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/parameterized_uart_rx.sv
// UART receiver: synchronises rx, validates the start bit, samples each bit at its centre,
// checks parity and stop bits, and strobes one word per frame.
module parameterized_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50000,
    parameter int BAUD_RATE   = 1000,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF    = half_bit(CPB);
    localparam int TIMER_W = $clog2(CPB);
    localparam int IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TIMER_W-1:0] HALF_END = TIMER_W'(HALF - 1);
    localparam logic [TIMER_W-1:0] BIT_END  = TIMER_W'(CPB - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic PAR_EN_B = (PARITY_EN != 0);
    localparam logic PAR_ODD_B = (PARITY_TYPE == PAR_ODD);
    localparam logic TWO_STOP = (STOP_BITS == 2);

    logic rx_s;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(rx),
        .sync_out(rx_s)
    );

    uart_state_e           state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  stop_bad_q, stop_bad_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rx_busy_q, rx_busy_d;
    logic                  stop_bad_now;

    // The final stop sample must count towards frame_err on the same cycle it is taken.
    assign stop_bad_now = stop_bad_q | ~rx_s;

    // NOTE: every _d gets a default before the case so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_busy_d    = rx_busy_q;

        unique case (state_q)
            IDLE: begin
                timer_d    = '0;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                stop_bad_d = 1'b0;
                par_bad_d  = 1'b0;
                rx_busy_d  = 1'b0;
                if (!rx_s) begin
                    state_d   = START;
                    rx_busy_d = 1'b1;
                end
            end
            START: begin
                if (timer_q == HALF_END) begin
                    timer_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d   = IDLE;
                        rx_busy_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        state_d   = PAR_EN_B ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PARITY: begin
                if (timer_q == BIT_END) begin
                    timer_d   = '0;
                    par_bad_d = PAR_ODD_B ^ (^shift_q) ^ rx_s;
                    state_d   = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    if (TWO_STOP && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        stop_bad_d = stop_bad_now;
                    end else begin
                        // Leaving at mid-stop lets a zero-gap next start bit be caught.
                        stop_idx_d   = 1'b0;
                        stop_bad_d   = 1'b0;
                        data_out_d   = shift_q;
                        parity_err_d = par_bad_q & PAR_EN_B;
                        frame_err_d  = stop_bad_now;
                        data_valid_d = 1'b1;
                        state_d      = rx_s ? IDLE : WAIT_HIGH;
                        rx_busy_d    = ~rx_s;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                timer_d = '0;
                if (rx_s) begin
                    state_d   = IDLE;
                    rx_busy_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                timer_d   = '0;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    // NOTE: the shift register is reset with the rest of the datapath; it is a handful of flops, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;

endmodule
